// File: rtl/zero_run_pkg.sv
// Shared types and constants for the zero/ones run-length monitor.
package zero_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ZRUN = 2'b01,
    ORUN = 2'b10
  } run_state_e;

  localparam logic [1:0] RT_NONE = 2'b00;
  localparam logic [1:0] RT_ZERO = 2'b01;
  localparam logic [1:0] RT_ONES = 2'b10;

  localparam logic [7:0] ZERO_BYTE = 8'h00;
  localparam logic [7:0] ONES_BYTE = 8'hFF;

endpackage

// File: rtl/zero_run_monitor_if.sv
// Byte stream, threshold/clear controls and run status of the run monitor.
interface zero_run_monitor_if #(parameter int RUN_W = 8);

  logic             in_valid;
  logic [7:0]       in_data;
  logic [RUN_W-1:0] thresh;
  logic             clr_alarm;
  logic             zero_flag;
  logic             ones_flag;
  logic [1:0]       run_type;
  logic [RUN_W-1:0] run_len;
  logic             alarm;
  logic             alarm_type;

  modport master (
    output in_valid, in_data, thresh, clr_alarm,
    input  zero_flag, ones_flag, run_type, run_len, alarm, alarm_type
  );

  modport slave (
    input  in_valid, in_data, thresh, clr_alarm,
    output zero_flag, ones_flag, run_type, run_len, alarm, alarm_type
  );

endinterface

// File: rtl/zero_run_monitor_byte_class.sv
// Combinational byte classifier: all-zeros / all-ones via a two-level reduction tree.
// Zero latency, no flow control.
module byte_class (
  input  logic [7:0] in_data,
  output logic       is_zero,
  output logic       is_ones
);

  logic [3:0] pair_or;
  logic [3:0] pair_and;

  for (genvar i = 0; i < 4; i++) begin : g_pair
    assign pair_or[i]  = in_data[2*i] | in_data[2*i+1];
    assign pair_and[i] = in_data[2*i] & in_data[2*i+1];
  end

  assign is_zero = ~((pair_or[0] | pair_or[1]) | (pair_or[2] | pair_or[3]));
  assign is_ones = (pair_and[0] & pair_and[1]) & (pair_and[2] & pair_and[3]);

endmodule

// File: rtl/zero_run_monitor.sv
// Zero/ones run-length supervisor with sticky threshold alarm; registered outputs, 1-cycle latency.
// No backpressure: every in_valid cycle is consumed.
module zero_run_monitor
  import zero_run_pkg::*;
#(
  parameter int RUN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  zero_run_monitor_if.slave  mon
);

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  run_state_e       state_q, state_d;
  logic [RUN_W-1:0] len_q, len_d, len_inc;
  logic             zf_q, zf_d, of_q, of_d;
  logic             al_q, al_d, at_q, at_d;
  logic             hit;
  logic             is_zero, is_ones;

  byte_class u_class (
    .in_data (mon.in_data),
    .is_zero (is_zero),
    .is_ones (is_ones)
  );

  assign len_inc = (len_q == RUN_MAX) ? RUN_MAX : len_q + RUN_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      al_q    <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      al_q    <= al_d;
      at_q    <= at_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    zf_d    = zf_q;
    of_d    = of_q;
    al_d    = al_q;
    at_d    = at_q;
    hit     = 1'b0;

    if (mon.in_valid) begin
      if (is_zero) begin
        state_d = ZRUN;
        len_d   = (state_q == ZRUN) ? len_inc : RUN_ONE;
        zf_d    = 1'b1;
        of_d    = 1'b0;
      end else if (is_ones) begin
        state_d = ORUN;
        len_d   = (state_q == ORUN) ? len_inc : RUN_ONE;
        zf_d    = 1'b0;
        of_d    = 1'b1;
      end else begin
        state_d = IDLE;
        len_d   = '0;
        zf_d    = 1'b0;
        of_d    = 1'b0;
      end
      hit = (mon.thresh != '0) && (state_d != IDLE) && (len_d >= mon.thresh);
    end

    // First cause is kept unless the same cycle also clears the alarm.
    if (hit) begin
      if (!al_q || mon.clr_alarm) at_d = (state_d == ORUN);
      al_d = 1'b1;
    end else if (mon.clr_alarm) begin
      al_d = 1'b0;
      at_d = 1'b0;
    end
  end

  assign mon.run_type   = state_q;
  assign mon.run_len    = len_q;
  assign mon.zero_flag  = zf_q;
  assign mon.ones_flag  = of_q;
  assign mon.alarm      = al_q;
  assign mon.alarm_type = at_q;

endmodule

// File: tb/tb_zero_run_monitor.sv
// Bench for zero_run_monitor: RUN_W=8 and RUN_W=3 instances share one stimulus stream.
module tb_zero_run_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  zero_run_monitor_if #(.RUN_W(8)) if8 ();
  zero_run_monitor_if #(.RUN_W(3)) if3 ();

  zero_run_monitor #(.RUN_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .mon(if8.slave));
  zero_run_monitor #(.RUN_W(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .mon(if3.slave));

  int checks = 0;
  int errors = 0;

  // Reference: history of accepted bytes since reset, alarm state per instance.
  logic [7:0] hist[$];
  logic       m_alarm[2];
  logic       m_atype[2];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] th;
    logic       clr;
    logic [1:0] rt;
    logic [7:0] len;
    logic       al;
    logic       at;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [7:0] b);
    if (b == 8'h00) return 1;
    if (b == 8'hFF) return 2;
    return 0;
  endfunction

  function automatic int model_len(input int k);
    int n;
    int cap;
    logic [7:0] last;
    if (hist.size() == 0) return 0;
    last = hist[hist.size()-1];
    if (cls_of(last) == 0) return 0;
    cap = (k == 0) ? 255 : 7;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      n++;
    end
    return (n > cap) ? cap : n;
  endfunction

  function automatic int model_cls();
    if (hist.size() == 0) return 0;
    return cls_of(hist[hist.size()-1]);
  endfunction

  task automatic model_update(input logic v, input logic [7:0] d, input logic [7:0] th,
                              input logic clr, input logic rn);
    int thr;
    int c;
    logic hitm;
    if (!rn) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        m_alarm[k] = 1'b0;
        m_atype[k] = 1'b0;
      end
    end else begin
      if (v) hist.push_back(d);
      c = model_cls();
      for (int k = 0; k < 2; k++) begin
        thr  = (k == 0) ? int'(th) : int'(th[2:0]);
        hitm = v && (thr != 0) && (c != 0) && (model_len(k) >= thr);
        if (hitm) begin
          if (!m_alarm[k] || clr) m_atype[k] = (c == 2);
          m_alarm[k] = 1'b1;
        end else if (clr) begin
          m_alarm[k] = 1'b0;
          m_atype[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_model();
    int c;
    c = model_cls();
    chk("m8_zero_flag", int'(if8.zero_flag), int'(c == 1));
    chk("m8_ones_flag", int'(if8.ones_flag), int'(c == 2));
    chk("m8_run_type",  int'(if8.run_type),  c);
    chk("m8_run_len",   int'(if8.run_len),   model_len(0));
    chk("m8_alarm",     int'(if8.alarm),     int'(m_alarm[0]));
    chk("m8_alarm_type",int'(if8.alarm_type),int'(m_atype[0]));
    chk("m3_zero_flag", int'(if3.zero_flag), int'(c == 1));
    chk("m3_ones_flag", int'(if3.ones_flag), int'(c == 2));
    chk("m3_run_type",  int'(if3.run_type),  c);
    chk("m3_run_len",   int'(if3.run_len),   model_len(1));
    chk("m3_alarm",     int'(if3.alarm),     int'(m_alarm[1]));
    chk("m3_alarm_type",int'(if3.alarm_type),int'(m_atype[1]));
  endtask

  // Drive one cycle, let the edge happen, then compare away from the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [7:0] th,
                      input logic clr, input logic rn);
    if8.in_valid = v;  if8.in_data = d;  if8.thresh = th;      if8.clr_alarm = clr;
    if3.in_valid = v;  if3.in_data = d;  if3.thresh = th[2:0]; if3.clr_alarm = clr;
    rst_n = rn;
    @(posedge clk);
    model_update(v, d, th, clr, rn);
    #1;
    check_model();
  endtask

  task automatic exp8(input string nm, input int rt, input int len, input int al, input int at);
    chk({nm, "_run_type"},   int'(if8.run_type),   rt);
    chk({nm, "_run_len"},    int'(if8.run_len),    len);
    chk({nm, "_alarm"},      int'(if8.alarm),      al);
    chk({nm, "_alarm_type"}, int'(if8.alarm_type), at);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  vec_t vecs[$];
  logic [7:0] rd;
  logic [7:0] rth;

  initial begin
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_reset();
    exp8("reset", 0, 0, 0, 0);
    chk("reset_zero_flag", int'(if8.zero_flag), 0);
    chk("reset_ones_flag", int'(if8.ones_flag), 0);

    // Basic threshold crossing, alarm clear, class changes with thresh disabled.
    vecs.push_back('{1'b1, 8'h00, 8'd4, 1'b0, 2'b01, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'd4, 1'b0, 2'b01, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'd4, 1'b0, 2'b01, 8'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'd4, 1'b0, 2'b01, 8'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'd0, 1'b1, 2'b01, 8'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, 8'd0, 1'b0, 2'b10, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, 8'd0, 1'b0, 2'b10, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'd0, 1'b0, 2'b01, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h5A, 8'd0, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].th, vecs[i].clr, 1'b1);
      exp8($sformatf("vec%0d", i), vecs[i].rt, vecs[i].len, vecs[i].al, vecs[i].at);
    end

    // Saturation on the 3-bit instance, then class change restarts at 1.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'h00, 8'd0, 1'b0, 1'b1);
      chk($sformatf("sat3_len_%0d", i), int'(if3.run_len), (i > 7) ? 7 : i);
    end
    step(1'b1, 8'hFF, 8'd0, 1'b0, 1'b1);
    chk("sat3_after_ff_len", int'(if3.run_len), 1);
    chk("sat3_after_ff_type", int'(if3.run_type), 2);

    // First cause wins; set beats a simultaneous clear and takes the new cause.
    do_reset();
    step(1'b1, 8'h00, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'd2, 1'b0, 1'b1);
    exp8("zalarm", 1, 2, 1, 0);
    step(1'b1, 8'hFF, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'd2, 1'b0, 1'b1);
    exp8("first_cause", 2, 2, 1, 0);
    step(1'b1, 8'hFF, 8'd2, 1'b1, 1'b1);
    exp8("set_beats_clr", 2, 3, 1, 1);
    step(1'b0, 8'h00, 8'd2, 1'b1, 1'b1);
    exp8("plain_clr", 2, 3, 0, 0);

    // Threshold lowered mid-run only takes effect at the next accepted byte.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'd10, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'd2, 1'b0, 1'b1);
    exp8("no_retro", 1, 3, 0, 0);
    step(1'b1, 8'h00, 8'd2, 1'b0, 1'b1);
    exp8("thr_next_byte", 1, 4, 1, 0);

    // Valid gaps hold the run.
    do_reset();
    step(1'b1, 8'h00, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'hFF, 8'd0, 1'b0, 1'b1);
      exp8($sformatf("gap%0d", i), 1, 1, 0, 0);
    end
    step(1'b1, 8'h00, 8'd0, 1'b0, 1'b1);
    exp8("gap_resume", 1, 2, 0, 0);

    // Reset mid-run with alarm raised; reset dominates valid and clear.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 8'd5, 1'b0, 1'b1);
    exp8("pre_rst", 1, 5, 1, 0);
    step(1'b1, 8'h00, 8'd5, 1'b1, 1'b0);
    exp8("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_zero_flag", int'(if8.zero_flag), 0);
    step(1'b1, 8'h00, 8'd5, 1'b0, 1'b1);
    exp8("post_rst", 1, 1, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    rd  = 8'h00;
    rth = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 10) rth = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 99) >= 60) begin
        case ($urandom_range(0, 3))
          0, 1:    rd = 8'h00;
          2:       rd = 8'hFF;
          default: rd = 8'($urandom);
        endcase
      end
      step(($urandom_range(0, 99) < 80), rd, rth,
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
